// File: rtl/sha_msg_sched.sv
// SHA-256 message schedule: expands one 512-bit block into 32 two-word beats.
// Optional SHA_SCHED_DBLBUF_EN adds a pending block buffer so blocks stream back to back.
module sha_msg_sched (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic [511:0] block_in,
    output logic         in_ready,
    input  logic         hold,
    output logic         w_valid,
    output logic [63:0]  W,
    output logic [5:0]   cycle,
    output logic         done
);
    // state | meaning
    // IDLE  | waiting for a block, no beat presented
    // RUN   | presenting beat p (0..31) of the loaded block
    typedef enum logic {IDLE, RUN} state_t;

    state_t       state_q, state_d;
    logic [31:0]  win_q [16];
    logic [31:0]  win_d [16];
    logic [4:0]   p_q, p_d;
    logic [63:0]  w_d;
    logic [5:0]   cycle_d;
    logic         valid_d, done_d;
    logic         accept, start;
    logic [511:0] src;
    logic [31:0]  new0, new1;
`ifdef SHA_SCHED_DBLBUF_EN
    logic [511:0] pend_q, pend_d;
    logic         pend_full_q, pend_full_d, pend_release;
`endif

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Window holds W[2p .. 2p+15]; the two words appended are W[2p+16], W[2p+17].
    assign new0 = sig1(win_q[14]) + win_q[9]  + sig0(win_q[1]) + win_q[0];
    assign new1 = sig1(win_q[15]) + win_q[10] + sig0(win_q[2]) + win_q[1];

`ifdef SHA_SCHED_DBLBUF_EN
    assign pend_release = (state_q == RUN) && !hold && (p_q == 5'd31) && pend_full_q;
    assign in_ready     = !pend_full_q || pend_release;
`else
    assign in_ready     = (state_q == IDLE);
`endif
    assign accept = load && in_ready;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        p_d     = p_q;
        w_d     = W;
        cycle_d = cycle;
        valid_d = w_valid;
        done_d  = done;
        start   = 1'b0;
        src     = block_in;
`ifdef SHA_SCHED_DBLBUF_EN
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
`endif
        case (state_q)
            IDLE: start = accept;
            RUN: begin
                if (!hold) begin
                    if (p_q == 5'd31) begin
                        state_d = IDLE;
                        p_d     = 5'd0;
                        w_d     = 64'd0;
                        cycle_d = 6'd0;
                        valid_d = 1'b0;
                        done_d  = 1'b0;
`ifdef SHA_SCHED_DBLBUF_EN
                        if (pend_full_q) begin
                            start       = 1'b1;
                            src         = pend_q;
                            pend_full_d = 1'b0;
                        end
`endif
                    end else begin
                        for (int i = 0; i < 14; i++) win_d[i] = win_q[i+2];
                        win_d[14] = new0;
                        win_d[15] = new1;
                        p_d       = p_q + 5'd1;
                        w_d       = {win_q[3], win_q[2]};
                        cycle_d   = {1'b0, p_q} + 6'd2;
                        done_d    = (p_q == 5'd30);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            for (int i = 0; i < 16; i++) win_d[i] = src[32*i +: 32];
            state_d = RUN;
            p_d     = 5'd0;
            w_d     = src[63:0];
            cycle_d = 6'd1;
            valid_d = 1'b1;
            done_d  = 1'b0;
        end
`ifdef SHA_SCHED_DBLBUF_EN
        // A block arriving mid-run (including the release cycle) parks in the buffer.
        if (accept && state_q == RUN) begin
            pend_d      = block_in;
            pend_full_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            for (int i = 0; i < 16; i++) win_q[i] <= 32'd0;
            p_q     <= 5'd0;
            W       <= 64'd0;
            cycle   <= 6'd0;
            w_valid <= 1'b0;
            done    <= 1'b0;
`ifdef SHA_SCHED_DBLBUF_EN
            pend_q      <= 512'd0;
            pend_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
            p_q     <= p_d;
            W       <= w_d;
            cycle   <= cycle_d;
            w_valid <= valid_d;
            done    <= done_d;
`ifdef SHA_SCHED_DBLBUF_EN
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
`endif
        end
    end
endmodule

// File: tb/tb_sha_msg_sched.sv
// Scoreboard bench for sha_msg_sched: a reference SHA-256 schedule feeds the queue,
// a negedge monitor checks each presented beat, plus directed timing checks.
module tb_sha_msg_sched;
    logic         clk = 0;
    logic         n_rst = 0;
    logic         load = 0;
    logic [511:0] block_in = '0;
    logic         in_ready;
    logic         hold = 0;
    logic         w_valid;
    logic [63:0]  W;
    logic [5:0]   cycle;
    logic         done;

    sha_msg_sched dut (
        .clk(clk), .n_rst(n_rst), .load(load), .block_in(block_in),
        .in_ready(in_ready), .hold(hold), .w_valid(w_valid), .W(W),
        .cycle(cycle), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    int valid_cnt = 0;
    int b2b_done_cyc = -1;
    int b2b_gap = -1;
    logic b2b_mode = 0;
    logic [70:0] sb_q [$];
    logic [31:0] mw [64];
    logic [511:0] abc;

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ms1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic build(input logic [511:0] b);
        for (int i = 0; i < 16; i++) mw[i] = b[32*i +: 32];
        for (int t = 16; t < 64; t++)
            mw[t] = ms1(mw[t-2]) + mw[t-7] + ms0(mw[t-15]) + mw[t-16];
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor first (checks current beat), then enqueue any block accepted at the next edge.
    always @(negedge clk) begin
        if (n_rst && w_valid) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_beat", {58'd0, cycle}, 64'd0);
            end else begin
                chk("beat_W", W, sb_q[0][63:0]);
                chk("beat_cycle", {58'd0, cycle}, {58'd0, sb_q[0][69:64]});
                chk("beat_done", {63'd0, done}, {63'd0, sb_q[0][70]});
                if (!hold) begin
                    if (sb_q[0][70]) begin
                        done_cyc = cyc;
                        if (b2b_mode) b2b_done_cyc = cyc;
                    end
                    if (sb_q[0][69:64] == 6'd1 && b2b_mode && b2b_done_cyc >= 0 && b2b_gap < 0)
                        b2b_gap = cyc - b2b_done_cyc;
                    void'(sb_q.pop_front());
                end
            end
        end
        if (n_rst && load && in_ready) begin
            acc_cyc = cyc;
            build(block_in);
            for (int p = 0; p < 32; p++)
                sb_q.push_back({(p == 31), 6'(p + 1), mw[2*p+1], mw[2*p]});
        end
    end

    task automatic load_one(input logic [511:0] b);
        @(posedge clk); #1;
        load = 1; block_in = b;
        @(posedge clk); #1;
        load = 0;
    endtask

    task automatic wait_beat(input logic [5:0] c);
        int k;
        for (k = 0; k < 100; k++) begin
            if (w_valid && cycle == c) break;
            @(posedge clk); #1;
        end
        if (k == 100) chk("wait_beat_timeout", {58'd0, cycle}, {58'd0, c});
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 2000; k++) begin
            @(posedge clk); #1;
            if (!w_valid && sb_q.size() == 0 && in_ready) break;
        end
        if (k == 2000) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;

        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_w_valid", {63'd0, w_valid}, 64'd0);
        chk("rst_W", W, 64'd0);
        chk("rst_cycle", {58'd0, cycle}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        #20 n_rst = 1;

        // "abc" block, no hold
        valid_cnt = 0;
        load_one(abc);
        chk("abc_b0_W", W, 64'h00000000_61626380);
        chk("abc_b0_cycle", {58'd0, cycle}, 64'd1);
        wait_beat(6'd8);
        chk("abc_b7_W", W, 64'h00000018_00000000);
        @(posedge clk); #1;
        chk("abc_b8_W", W, 64'h000F0000_61626380);
        chk("abc_b8_cycle", {58'd0, cycle}, 64'd9);
        wait_idle();
        chk("abc_valid_cycles", 64'(valid_cnt), 64'd32);
        chk("abc_done_latency", 64'(done_cyc - acc_cyc), 64'd32);

        // hold for 3 cycles at beat 10
        valid_cnt = 0;
        load_one(abc);
        wait_beat(6'd11);
        hold = 1;
        repeat (3) begin @(posedge clk); #1; end
        hold = 0;
        wait_idle();
        chk("hold_valid_cycles", 64'(valid_cnt), 64'd35);
        chk("hold_done_latency", 64'(done_cyc - acc_cyc), 64'd35);

        // hold in IDLE has no effect
        hold = 1;
        load_one(abc);
        chk("idle_hold_b0_cycle", {58'd0, cycle}, 64'd1);
        hold = 0;
        wait_idle();

        // async reset mid-block at beat 15
        load_one(abc);
        wait_beat(6'd16);
        #1 n_rst = 0;
        #1;
        chk("mid_rst_w_valid", {63'd0, w_valid}, 64'd0);
        chk("mid_rst_W", W, 64'd0);
        chk("mid_rst_cycle", {58'd0, cycle}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        sb_q.delete();
        @(posedge clk); #2 n_rst = 1;
        load_one(abc);
        chk("post_rst_valid", {63'd0, w_valid}, 64'd1);
        chk("post_rst_b0_W", W, 64'h00000000_61626380);
        chk("post_rst_b0_cycle", {58'd0, cycle}, 64'd1);
        wait_idle();

        // load held high: back-to-back blocks
        b2b_mode = 1;
        @(posedge clk); #1;
        load = 1; block_in = abc; block_in[63:32] = 32'hDEADBEEF;
        repeat (40) @(posedge clk);
        #1 load = 0;
        wait_idle();
        b2b_mode = 0;
`ifdef SHA_SCHED_DBLBUF_EN
        chk("b2b_gap", 64'(b2b_gap), 64'd1);
`else
        chk("b2b_gap", 64'(b2b_gap), 64'd2);
`endif

        // random blocks against the reference schedule
        for (int n = 0; n < 20; n++) begin
            logic [511:0] rb;
            for (int i = 0; i < 16; i++) rb[32*i +: 32] = $urandom;
            load_one(rb);
            if (n % 4 == 1) begin
                wait_beat(6'd20);
                hold = 1;
                @(posedge clk); #1;
                hold = 0;
            end
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
